// File: rtl/demux_ctrl.sv
// Byte demultiplexer controller: steers each accepted byte to the next enabled lane (round-robin),
// parking it in a one-entry hold register while the target lane is not ready.
module demux_ctrl (
   input  logic        clk,
   input  logic        reset_L,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
   output logic        in_ready,
   input  logic [3:0]  lane_mask,
   input  logic [3:0]  lane_ready,
   output logic [7:0]  data_out,
   output logic [3:0]  valid_out,
   output logic [1:0]  control,
   output logic [15:0] byte_cnt,
   output logic [7:0]  stall_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [7:0]  hold_q, hold_d;
   logic [1:0]  hold_lane_q, hold_lane_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [3:0]  valid_out_q, valid_out_d;
   logic [1:0]  control_q, control_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]  stall_cnt_q, stall_cnt_d;

   logic       accept;
   logic [1:0] tgt;
   logic [1:0] idx;
   logic       found;
   logic       dispatch;
   logic [1:0] disp_lane;
   logic [7:0] disp_data;

   assign in_ready = (state_q == RUN) && (|lane_mask);
   assign accept   = valid_in && in_ready;

   // First enabled lane at or after ptr, wrapping; idx is 2 bits so the sum wraps mod 4.
   always_comb begin
      tgt   = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && lane_mask[idx]) begin
            tgt   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      hold_lane_d = hold_lane_q;
      data_out_d  = data_out_q;
      valid_out_d = 4'b0000;
      control_d   = control_q;
      byte_cnt_d  = byte_cnt_q;
      stall_cnt_d = stall_cnt_q;
      dispatch    = 1'b0;
      disp_lane   = tgt;
      disp_data   = data_in;
      case (state_q)
         IDLE: begin
            if (|lane_mask) state_d = RUN;
         end
         RUN: begin
            if (accept) begin
               if (lane_ready[tgt]) begin
                  dispatch = 1'b1;
               end else begin
                  state_d     = STALL;
                  hold_d      = data_in;
                  hold_lane_d = tgt;
               end
            end else if (lane_mask == 4'b0000) begin
               state_d = IDLE;
            end
         end
         STALL: begin
            if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
            // Only the held lane matters here; lane_mask is deliberately not consulted.
            if (lane_ready[hold_lane_q]) begin
               dispatch  = 1'b1;
               disp_lane = hold_lane_q;
               disp_data = hold_q;
               state_d   = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      if (dispatch) begin
         data_out_d  = disp_data;
         valid_out_d = 4'b0001 << disp_lane;
         control_d   = disp_lane;
         ptr_d       = disp_lane + 2'd1;
         byte_cnt_d  = byte_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         hold_q      <= 8'd0;
         hold_lane_q <= 2'd0;
         data_out_q  <= 8'd0;
         valid_out_q <= 4'b0000;
         control_q   <= 2'd0;
         byte_cnt_q  <= 16'd0;
         stall_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         hold_lane_q <= hold_lane_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         control_q   <= control_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign control   = control_q;
   assign byte_cnt  = byte_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/demux_ctrl.md
DEMUX_CTRL -- requirements
Module: demux_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port valid_in, input, 1, input byte present.
REQ-004 SHALL have port data_in, input, 8, input byte.
REQ-005 SHALL have port in_ready, output, 1, byte accepted on a cycle with valid_in=1 and in_ready=1.
REQ-006 SHALL have port lane_mask, input, 4, lane n enabled when bit n=1.
REQ-007 SHALL have port lane_ready, input, 4, lane n can take a byte this cycle.
REQ-008 SHALL have port data_out, output, 8, registered byte to demux datapath.
REQ-009 SHALL have port valid_out, output, 4, registered one-hot lane strobe.
REQ-010 SHALL have port control, output, 2, registered index of last dispatched lane.
REQ-011 SHALL have port byte_cnt, output, 16, dispatched-byte count.
REQ-012 SHALL have port stall_cnt, output, 8, cycles spent in STALL.

Function
REQ-013 SHALL implement states IDLE, RUN, STALL, plus a 2-bit pointer ptr and an 8-bit hold register.
REQ-014 SHALL drive in_ready=1 only when state=RUN and lane_mask!=0 (combinational).
REQ-015 IDLE -> RUN on the next edge when lane_mask!=0; RUN -> IDLE on the next edge when lane_mask=0 and no acceptance.
REQ-016 Target lane SHALL be the first enabled lane at or after ptr, searched circularly (ptr, ptr+1, ..., mod 4).
REQ-017 On acceptance with lane_ready[target]=1, the next edge SHALL set data_out=data_in, valid_out=1<<target, control=target, ptr=(target+1) mod 4, and stay in RUN; latency is 1 cycle.
REQ-018 On acceptance with lane_ready[target]=0, the next edge SHALL:
  - store data_in and target in the hold register;
  - enter STALL, with valid_out=0.
REQ-019 In STALL, when lane_ready[held target]=1, the next edge SHALL dispatch the held byte as in REQ-017 and return to RUN.
REQ-020 In STALL, lane_mask changes SHALL be ignored until the held byte is dispatched.
REQ-021 valid_out SHALL be high for exactly one cycle per dispatch, otherwise 4'b0000.
REQ-022 data_out and control SHALL hold their last dispatched values between dispatches.
REQ-023 byte_cnt SHALL increment by 1 per dispatch, wrapping 0xFFFF -> 0x0000.
REQ-024 stall_cnt SHALL increment each cycle the state is STALL, saturating at 0xFF.
REQ-025 A byte SHALL never be dropped or duplicated; valid_in while in_ready=0 has no effect.
REQ-026 If lane_mask drops to 0 in the same cycle as an acceptance, the mask sampled that cycle governs and the byte SHALL still be dispatched or held.

Reset
REQ-027 reset_L=0 SHALL immediately force: state=IDLE, ptr=0, hold=0, data_out=0, valid_out=0, control=0, byte_cnt=0, stall_cnt=0, in_ready=0.
REQ-028 Reset asserted mid-STALL SHALL discard the held byte with no dispatch.
REQ-029 After reset_L rises, the first possible acceptance SHALL be one cycle after IDLE->RUN.

Verification
REQ-030 lane_mask=4'hF, lane_ready=4'hF, bytes 0xA0..0xA5 back-to-back -> valid_out 1,2,4,8,1,2; control 0,1,2,3,0,1; data_out matches, each 1 cycle after its input; byte_cnt=6.
REQ-031 lane_mask=4'b1010, all lanes ready, 4 bytes -> lanes 1,3,1,3; lanes 0 and 2 never strobed.
REQ-032 All lanes ready except lane_ready[2]=0 for 5 cycles when byte 0x5C targets lane 2 -> in_ready=0, STALL for 5 cycles, stall_cnt=5, then valid_out=4'b0100 with data_out=0x5C, then in_ready=1.
REQ-033 lane_mask=0 -> in_ready stays 0 and IDLE is held; setting lane_mask=4'h1 -> RUN after 1 edge, all bytes go to lane 0.
REQ-034 reset_L pulsed low during STALL -> all outputs 0 immediately, no dispatch of held byte, ptr restarts at lane 0.
REQ-035 byte_cnt preloaded by 65536 dispatches -> wraps to 0x0000; 300 stall cycles -> stall_cnt=0xFF.
